// File: rtl/viterbi_pkg.sv
// Code constants and FSM encoding shared by the transmit encoder and the Viterbi decoder stages,
// so both ends of the link agree on the same code.
package viterbi_pkg;
  localparam int K      = 3;   // constraint length
  localparam int RATE_N = 2;   // coded bits per input bit (rate 1/2)

  localparam logic [K-1:0] POLY_A_DEF = 3'b101;
  localparam logic [K-1:0] POLY_B_DEF = 3'b111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TAIL1 = 2'd1,
    TAIL2 = 2'd2
  } enc_state_t;
endpackage

// File: rtl/conv_symbol_gen.sv
// Combinational symbol generator: {C0, C1} = parity of the encoder vector under each generator.
// Zero latency, no flow control; also reusable for decoder branch-metric expected symbols.
module conv_symbol_gen
  import viterbi_pkg::*;
(
  input  logic [K-1:0]      poly_a,
  input  logic [K-1:0]      poly_b,
  input  logic [K-1:0]      v,
  output logic [RATE_N-1:0] sym
);
  assign sym = {^(v & poly_a), ^(v & poly_b)};
endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder with 2-bit zero tail per frame; symbol one cycle after accept.
// Single output register: input stalls whenever the held symbol is not taken by out_ready.
module conv_encoder_tx
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] POLY_A = POLY_A_DEF,
  parameter logic [K-1:0] POLY_B = POLY_B_DEF,
  parameter int           CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sym_out,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt
);
  enc_state_t        state, state_nxt;
  logic [K-2:0]      sr;
  logic              slot_free;
  logic              load;
  logic              u;
  logic              last_nxt;
  logic              cnt_inc;
  logic [RATE_N-1:0] sym;

  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    u         = 1'b0;
    last_nxt  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          load = 1'b1;
          u    = in_bit;
          if (in_last) state_nxt = TAIL1;
        end
      end
      TAIL1: begin
        if (slot_free) begin
          load      = 1'b1;
          state_nxt = TAIL2;
        end
      end
      TAIL2: begin
        if (slot_free) begin
          load      = 1'b1;
          last_nxt  = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  conv_symbol_gen u_sym_gen (
    .poly_a (POLY_A),
    .poly_b (POLY_B),
    .v      ({u, sr}),
    .sym    (sym)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      sr        <= '0;
      out_valid <= 1'b0;
      sym_out   <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sr        <= {u, sr[K-2]};
        out_valid <= 1'b1;
        sym_out   <= sym;
        out_last  <= last_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      // Counted on the edge that loads the closing tail symbol
      if (cnt_inc) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end
endmodule
